// File: rtl/universal_register_pkg.sv
// Shared encodings for universal_register: shift modes and control FSM states.
package universal_register_pkg;

   typedef enum logic [1:0] {
      MODE_LOGIC  = 2'b00,
      MODE_ARITH  = 2'b01,
      MODE_ROTATE = 2'b10,
      MODE_RSVD   = 2'b11
   } sh_mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/universal_register_shift_counter.sv
// Step counter for multi-cycle shifts: loads the step count, counts down,
// flags the final step.
module shift_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] amt,
   output logic             last
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   count <= '0;
      else if (clr)                 count <= '0;
      else if (load)                count <= amt;
      else if (dec && count != '0)  count <= count - 1'b1;
   end

   assign last = (count == WIDTH'(1));

endmodule

// File: rtl/universal_register.sv
// Universal register: clear, load, wrapping/saturating inc/dec and a
// multi-cycle single-bit-per-clock shifter with busy/done handshake.
module universal_register
   import universal_register_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int SH_WIDTH   = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cl,
   input  logic                  ld,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  inc,
   input  logic                  dec,
   input  logic                  sat,
   input  logic                  sh_start,
   input  logic                  sh_dir,
   input  logic [1:0]            sh_mode,
   input  logic [SH_WIDTH-1:0]   sh_amt,
   input  logic                  si,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  carry,
   output logic                  busy,
   output logic                  done,
   output logic                  zero,
   output logic                  neg
);

   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   state_t                state, state_next;
   logic [DATA_WIDTH-1:0] out_next;
   logic                  carry_next;
   logic                  cap_dir, cap_si;
   sh_mode_t              cap_mode;
   logic                  capture, cnt_clr, cnt_load, cnt_dec, last;
   logic [DATA_WIDTH:0]   stepped;

   // Returns {ejected_bit, shifted_value} for one single-bit step.
   function automatic logic [DATA_WIDTH:0] shift_step(input logic [DATA_WIDTH-1:0] v,
                                                      input logic dir, input sh_mode_t mode,
                                                      input logic fill_si);
      logic fill, ejected;
      ejected = dir ? v[DATA_WIDTH-1] : v[0];
      case (mode)
         MODE_ARITH:  fill = dir ? 1'b0 : v[DATA_WIDTH-1];
         MODE_ROTATE: fill = ejected;
         default:     fill = fill_si;
      endcase
      if (dir) shift_step = {ejected, v[DATA_WIDTH-2:0], fill};
      else     shift_step = {ejected, fill, v[DATA_WIDTH-1:1]};
   endfunction

   shift_counter #(.WIDTH(SH_WIDTH)) u_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .load  (cnt_load),
      .dec   (cnt_dec),
      .amt   (sh_amt),
      .last  (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         out      <= '0;
         carry    <= 1'b0;
         cap_dir  <= 1'b0;
         cap_si   <= 1'b0;
         cap_mode <= MODE_LOGIC;
      end else begin
         state <= state_next;
         out   <= out_next;
         carry <= carry_next;
         if (capture) begin
            cap_dir  <= sh_dir;
            cap_si   <= si;
            cap_mode <= (sh_mode_t'(sh_mode) == MODE_RSVD) ? MODE_LOGIC : sh_mode_t'(sh_mode);
         end
      end
   end

   always_comb begin
      state_next = state;
      out_next   = out;
      carry_next = carry;
      cnt_clr    = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      capture    = 1'b0;
      stepped    = shift_step(out, cap_dir, cap_mode, cap_si);
      case (state)
         SHIFT: begin
            // Only clear may interrupt a shift in flight.
            if (cl) begin
               out_next   = '0;
               carry_next = 1'b0;
               state_next = IDLE;
               cnt_clr    = 1'b1;
            end else begin
               {carry_next, out_next} = stepped;
               cnt_dec = 1'b1;
               if (last) state_next = DONE;
            end
         end
         default: begin
            state_next = IDLE;
            if (cl) begin
               out_next   = '0;
               carry_next = 1'b0;
            end else if (ld) begin
               out_next   = in;
               carry_next = 1'b0;
            end else if (inc) begin
               if (&out) begin
                  carry_next = 1'b1;
                  out_next   = sat ? out : '0;
               end else begin
                  carry_next = 1'b0;
                  out_next   = out + ONE;
               end
            end else if (dec) begin
               if (out == '0) begin
                  carry_next = 1'b1;
                  out_next   = sat ? out : '1;
               end else begin
                  carry_next = 1'b0;
                  out_next   = out - ONE;
               end
            end else if (sh_start) begin
               if (sh_amt == '0) begin
                  state_next = DONE;
               end else begin
                  state_next = SHIFT;
                  cnt_load   = 1'b1;
                  capture    = 1'b1;
               end
            end
         end
      endcase
   end

   assign busy = (state == SHIFT);
   assign done = (state == DONE);
   assign zero = (out == '0);
   assign neg  = out[DATA_WIDTH-1];

endmodule

// File: tb/tb_universal_register.sv
// Randomized and directed bench for universal_register against a behavioural
// model built on integer arithmetic.
module tb_universal_register;

   localparam int W    = 16;
   localparam int MAXV = (1 << W) - 1;
   localparam int HALF = 1 << (W - 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cl, ld, inc, dec, sat, sh_start, sh_dir, si;
   logic [1:0]    sh_mode;
   logic [3:0]    sh_amt;
   logic [W-1:0]  din, dout;
   logic          carry, busy, done, zero, neg;

   int total = 0;
   int bad   = 0;

   int m_out, m_rem, c_mode;
   bit m_carry, m_busy, m_done, c_dir, c_si;

   universal_register #(.DATA_WIDTH(W), .SH_WIDTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cl       (cl),
      .ld       (ld),
      .in       (din),
      .inc      (inc),
      .dec      (dec),
      .sat      (sat),
      .sh_start (sh_start),
      .sh_dir   (sh_dir),
      .sh_mode  (sh_mode),
      .sh_amt   (sh_amt),
      .si       (si),
      .out      (dout),
      .carry    (carry),
      .busy     (busy),
      .done     (done),
      .zero     (zero),
      .neg      (neg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_out = 0; m_carry = 0; m_busy = 0; m_done = 0; m_rem = 0;
   endtask

   task automatic model_step();
      int ej, fill;
      if (c_dir) begin
         ej   = m_out / HALF;
         fill = (c_mode == 1) ? 0 : (c_mode == 2) ? ej : c_si;
         m_out = (m_out * 2) % (MAXV + 1) + fill;
      end else begin
         ej   = m_out % 2;
         fill = (c_mode == 1) ? m_out / HALF : (c_mode == 2) ? ej : c_si;
         m_out = m_out / 2 + fill * HALF;
      end
      m_carry = (ej != 0);
   endtask

   task automatic model_clock();
      if (!rst_n) begin
         model_reset();
      end else if (m_busy) begin
         if (cl) begin
            m_out = 0; m_carry = 0; m_busy = 0; m_done = 0;
         end else begin
            model_step();
            m_rem--;
            if (m_rem == 0) begin m_busy = 0; m_done = 1; end
         end
      end else begin
         m_done = 0;
         if (cl) begin
            m_out = 0; m_carry = 0;
         end else if (ld) begin
            m_out = int'(din); m_carry = 0;
         end else if (inc) begin
            if (m_out == MAXV) begin m_carry = 1; if (!sat) m_out = 0; end
            else begin m_out++; m_carry = 0; end
         end else if (dec) begin
            if (m_out == 0) begin m_carry = 1; if (!sat) m_out = MAXV; end
            else begin m_out--; m_carry = 0; end
         end else if (sh_start) begin
            c_dir  = sh_dir;
            c_si   = si;
            c_mode = (sh_mode == 2'd3) ? 0 : int'(sh_mode);
            if (sh_amt == 0) m_done = 1;
            else begin m_busy = 1; m_rem = int'(sh_amt); end
         end
      end
   endtask

   task automatic check_all();
      chk("out", int'(dout), m_out);
      chk("carry", int'(carry), int'(m_carry));
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("zero", int'(zero), int'(m_out == 0));
      chk("neg", int'(neg), int'(m_out >= HALF));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_clock();
      #1;
      check_all();
   endtask

   task automatic quiet();
      cl = 0; ld = 0; inc = 0; dec = 0; sh_start = 0;
   endtask

   task automatic do_ld(input logic [W-1:0] v);
      quiet(); ld = 1; din = v; cycle(); ld = 0;
   endtask

   task automatic start_shift(input logic dir, input logic [1:0] mode, input logic [3:0] amt,
                              input logic fill);
      quiet(); sh_start = 1; sh_dir = dir; sh_mode = mode; sh_amt = amt; si = fill;
      cycle(); sh_start = 0;
   endtask

   // Drops rst_n between edges, checks the immediate effect, releases at a negedge.
   task automatic async_reset();
      #2;
      rst_n = 0;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1;
   endtask

   logic [W-1:0] exp36 [4] = '{16'hC000, 16'hE000, 16'hF000, 16'hF800};
   int busy_cnt, done_cnt;

   initial begin
      quiet(); sat = 0; sh_dir = 0; sh_mode = 0; sh_amt = 0; si = 0; din = '0;
      model_reset();
      #1;
      check_all();
      #12;
      @(negedge clk);
      rst_n = 1;
      cycle();

      // Wrapping and saturating increment at all-ones.
      do_ld(16'hFFFF);
      inc = 1; sat = 0; cycle(); inc = 0;
      chk("r035_wrap_out", int'(dout), 0);
      chk("r035_wrap_carry", int'(carry), 1);
      chk("r035_wrap_zero", int'(zero), 1);
      do_ld(16'hFFFF);
      inc = 1; sat = 1; cycle(); inc = 0;
      chk("r035_sat_out", int'(dout), 16'hFFFF);
      chk("r035_sat_carry", int'(carry), 1);
      dec = 1; sat = 0; do_ld(16'h0000); dec = 1; cycle(); dec = 0;
      chk("dec_wrap_out", int'(dout), 16'hFFFF);
      chk("dec_wrap_borrow", int'(carry), 1);

      // Arithmetic right by 4 from 0x8001.
      do_ld(16'h8001);
      start_shift(1'b0, 2'b01, 4'd4, 1'b0);
      busy_cnt = int'(busy);
      for (int i = 0; i < 4; i++) begin
         si = ~si; sh_mode = 2'b10;
         cycle();
         chk("r036_step", int'(dout), int'(exp36[i]));
         busy_cnt += int'(busy);
      end
      chk("r036_busy_cycles", busy_cnt, 4);
      chk("r036_done", int'(done), 1);
      chk("r036_carry", int'(carry), 0);
      cycle();
      chk("r036_done_drop", int'(done), 0);

      // Rotate left by 15 from 0x0001.
      do_ld(16'h0001);
      start_shift(1'b1, 2'b10, 4'd15, 1'b1);
      done_cnt = 0;
      for (int i = 0; i < 17; i++) begin
         cycle();
         done_cnt += int'(done);
         if (i == 14) begin
            chk("r037_out", int'(dout), 16'h8000);
            chk("r037_carry", int'(carry), 0);
         end
      end
      chk("r037_done_pulses", done_cnt, 1);

      // Clear aborts a logical right shift; simultaneous load ignored.
      do_ld(16'h8001);
      start_shift(1'b0, 2'b00, 4'd3, 1'b0);
      cycle();
      cl = 1; ld = 1; din = 16'h1234; cycle(); quiet();
      chk("r038_out", int'(dout), 0);
      chk("r038_busy", int'(busy), 0);
      cycle();
      chk("r038_no_done", int'(done), 0);

      // Zero-length shift.
      do_ld(16'h5AA5);
      start_shift(1'b1, 2'b00, 4'd0, 1'b1);
      chk("r039_done", int'(done), 1);
      chk("r039_busy", int'(busy), 0);
      chk("r039_out", int'(dout), 16'h5AA5);
      cycle();
      chk("r039_done_drop", int'(done), 0);

      // Asynchronous reset in the middle of a shift, then a normal load.
      do_ld(16'hF0F0);
      start_shift(1'b1, 2'b01, 4'd6, 1'b0);
      cycle();
      async_reset();
      chk("r040_out", int'(dout), 0);
      chk("r040_busy", int'(busy), 0);
      do_ld(16'h3C3C);
      chk("r040_ld", int'(dout), 16'h3C3C);

      // Random command mix.
      for (int n = 0; n < 600; n++) begin
         cl       = ($urandom_range(0, 29) == 0);
         ld       = ($urandom_range(0, 5) == 0);
         inc      = ($urandom_range(0, 3) == 0);
         dec      = ($urandom_range(0, 3) == 0);
         sh_start = ($urandom_range(0, 3) == 0);
         sat      = 1'(($urandom() & 1));
         sh_dir   = 1'(($urandom() & 1));
         si       = 1'(($urandom() & 1));
         sh_mode  = 2'($urandom_range(0, 3));
         sh_amt   = 4'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       din = 16'hFFFF;
            1:       din = 16'h0000;
            default: din = 16'($urandom());
         endcase
         cycle();
         if ($urandom_range(0, 149) == 0) async_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
